// File: rtl/types_pkg.sv
// types_pkg: shared bus and access-size types plus the store-buffer entry layout.
package types_pkg;
    typedef logic [31:0] DATA_BUS;
    typedef enum logic [1:0] {Byte = 2'd0, Half = 2'd1, Word = 2'd2} byte_format;
    typedef struct packed {
        DATA_BUS    addr;
        DATA_BUS    data;
        byte_format fmt;
    } sb_entry_t;
    localparam int SB_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/sb_match.sv
// sb_match: combinational word-address search over the occupied FIFO slots, reporting the newest hit.
module sb_match import types_pkg::*; #(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic [29:0]   wordAddr [DEPTH],
    input  byte_format    fmts [DEPTH],
    input  logic [PW-1:0] head,
    input  logic [CW-1:0] count,
    input  logic [29:0]   ldWord,
    output logic          hit,
    output logic [PW-1:0] hitIdx,
    output byte_format    hitFmt
);
    logic [PW-1:0] idx;
    always_comb begin
        hit = 1'b0;
        hitIdx = '0;
        hitFmt = Word;
        idx = '0;
        // oldest to newest, so the last hit seen is the newest store
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count && wordAddr[idx] == ldWord) begin
                hit = 1'b1;
                hitIdx = idx;
                hitFmt = fmts[idx];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: FIFO of pending stores that drains into the data-memory port whenever no load owns it.
// Define STORE_BUFFER_FWD_EN to forward a buffered Word store to a matching Word load instead of stalling.
module store_buffer import types_pkg::*; #(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       st_valid,
    output logic       st_ready,
    input  DATA_BUS    st_addr,
    input  DATA_BUS    st_data,
    input  byte_format st_fmt,
    input  logic       ld_valid,
    input  DATA_BUS    ld_addr,
    input  byte_format ld_fmt,
    output logic       ld_stall,
    output logic       ld_fwd,
    output DATA_BUS    ld_fwd_data,
    output logic       mem_WE,
    output DATA_BUS    mem_A,
    output DATA_BUS    mem_WD,
    output byte_format mem_ByteSelect,
    output logic       empty
);
`ifdef STORE_BUFFER_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif
    sb_entry_t     entries [DEPTH];
    logic [29:0]   wordAddr [DEPTH];
    byte_format    fmts [DEPTH];
    logic [PW-1:0] head, tail, hitIdx;
    logic [CW-1:0] count;
    logic          hit, push, pop;
    byte_format    hitFmt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        assign wordAddr[i] = entries[i].addr[31:2];
        assign fmts[i] = entries[i].fmt;
    end

    sb_match #(.DEPTH(DEPTH)) u_match (
        .wordAddr(wordAddr),
        .fmts(fmts),
        .head(head),
        .count(count),
        .ldWord(ld_addr[31:2]),
        .hit(hit),
        .hitIdx(hitIdx),
        .hitFmt(hitFmt)
    );

    always_comb begin
        st_ready = count < CW'(DEPTH);
        empty = count == '0;
        push = st_valid && st_ready;
        ld_fwd = FwdEn && ld_valid && hit && ld_fmt == Word && hitFmt == Word;
        ld_fwd_data = ld_fwd ? entries[hitIdx].data : '0;
        ld_stall = ld_valid && hit && !ld_fwd;
        // a stalled load yields the port so the blocking store can drain
        pop = rst_n && count != '0 && (!ld_valid || ld_stall);
        mem_WE = pop;
        mem_A = pop ? entries[head].addr : ld_valid ? ld_addr : '0;
        mem_WD = pop ? entries[head].data : '0;
        mem_ByteSelect = pop ? entries[head].fmt : ld_valid ? ld_fmt : Word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) begin
                entries[tail] <= '{addr: st_addr, data: st_data, fmt: st_fmt};
                tail <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus random traffic checked against a queue-based store-buffer model.
module tb_store_buffer;
    import types_pkg::*;
    localparam int DEPTH = 4;
`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n, st_valid, st_ready, ld_valid, ld_stall, ld_fwd, mem_WE, empty;
    DATA_BUS    st_addr, st_data, ld_addr, ld_fwd_data, mem_A, mem_WD;
    byte_format st_fmt, ld_fmt, mem_ByteSelect;
    int         checks = 0, failures = 0;
    sb_entry_t  q[$];
    logic       expDrain, expReady;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_fmt(st_fmt),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_fmt(ld_fmt),
        .ld_stall(ld_stall), .ld_fwd(ld_fwd), .ld_fwd_data(ld_fwd_data),
        .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_ByteSelect(mem_ByteSelect),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs and compare every output against the model.
    task automatic drive(logic r, logic sv, DATA_BUS sa, DATA_BUS sd, byte_format sf,
                         logic lv, DATA_BUS la, byte_format lf);
        int   m;
        logic fwd, stall;
        rst_n = r; st_valid = sv; st_addr = sa; st_data = sd; st_fmt = sf;
        ld_valid = lv; ld_addr = la; ld_fmt = lf;
        #1;
        m = -1;
        for (int i = q.size() - 1; i >= 0; i--)
            if (m < 0 && q[i].addr[31:2] == la[31:2]) m = i;
        fwd = FWD && lv && m >= 0 && lf == Word && q[m].fmt == Word;
        stall = lv && m >= 0 && !fwd;
        expReady = q.size() < DEPTH;
        expDrain = r && q.size() > 0 && (!lv || stall);
        chk("st_ready", 32'(st_ready), 32'(expReady));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("ld_stall", 32'(ld_stall), 32'(stall));
        chk("ld_fwd", 32'(ld_fwd), 32'(fwd));
        chk("ld_fwd_data", ld_fwd_data, fwd ? q[m].data : 32'h0);
        chk("mem_WE", 32'(mem_WE), 32'(expDrain));
        chk("mem_A", mem_A, expDrain ? q[0].addr : lv ? la : 32'h0);
        chk("mem_ByteSelect", 32'(mem_ByteSelect), 32'(expDrain ? q[0].fmt : lv ? lf : Word));
        if (expDrain || !lv) chk("mem_WD", mem_WD, expDrain ? q[0].data : 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) q.delete();
        else begin
            if (expDrain) void'(q.pop_front());
            if (st_valid && expReady) q.push_back('{addr: st_addr, data: st_data, fmt: st_fmt});
        end
        #1;
    endtask

    task automatic pushHold(DATA_BUS a, DATA_BUS d, byte_format f);
        drive(1'b1, 1'b1, a, d, f, 1'b1, 32'hF00, Word);
        tick();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h0, Word, 1'b0, 32'h0, Word);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_fmt = Word;
        ld_valid = 1'b0; ld_addr = '0; ld_fmt = Word;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h0, 32'h0, Word, 1'b0, 32'h0, Word);
        chk("rst_ready", 32'(st_ready), 32'h1);
        chk("rst_empty", 32'(empty), 32'h1);
        tick();
        // single store drains the following cycle
        drive(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, Word, 1'b0, 32'h0, Word);
        chk("t1_no_early_drain", 32'(mem_WE), 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h0, Word, 1'b0, 32'h0, Word);
        chk("t1_we", 32'(mem_WE), 32'h1);
        chk("t1_a", mem_A, 32'h100);
        chk("t1_wd", mem_WD, 32'hDEADBEEF);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h0, Word, 1'b0, 32'h0, Word);
        chk("t1_empty", 32'(empty), 32'h1);
        tick();
        // fill while loads hold the port, then drain in order
        for (int i = 0; i < 4; i++) pushHold(32'h400 + 32'(4 * i), 32'hA0 + 32'(i), Word);
        drive(1'b1, 1'b0, 32'h0, 32'h0, Word, 1'b1, 32'hF00, Word);
        chk("t2_full", 32'(st_ready), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h0, Word, 1'b0, 32'h0, Word);
            chk("t2_order", mem_A, 32'h400 + 32'(4 * i));
            tick();
        end
        idle(1);
        // newest matching Word store is forwarded (or stalls without forwarding)
        pushHold(32'h200, 32'h11, Word);
        pushHold(32'h200, 32'h22, Word);
        drive(1'b1, 1'b0, 32'h0, 32'h0, Word, 1'b1, 32'h200, Word);
        chk("t3_fwd", 32'(ld_fwd), 32'(FWD));
        chk("t3_data", ld_fwd_data, FWD ? 32'h22 : 32'h0);
        chk("t3_stall", 32'(ld_stall), 32'(!FWD));
        tick();
        idle(3);
        // partial-size overlap stalls until the store drains
        pushHold(32'h301, 32'hAB, Byte);
        drive(1'b1, 1'b0, 32'h0, 32'h0, Word, 1'b1, 32'h300, Word);
        chk("t4_stall", 32'(ld_stall), 32'h1);
        chk("t4_drain_a", mem_A, 32'h301);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h0, Word, 1'b1, 32'h300, Word);
        chk("t4_release", 32'(ld_stall), 32'h0);
        chk("t4_load_a", mem_A, 32'h300);
        chk("t4_load_we", 32'(mem_WE), 32'h0);
        tick();
        // full buffer: no bypass, then sustained push+pop across the pointer wrap
        for (int i = 0; i < 4; i++) pushHold(32'h500 + 32'(4 * i), 32'h50 + 32'(i), Half);
        drive(1'b1, 1'b1, 32'h600, 32'h60, Word, 1'b0, 32'h0, Word);
        chk("t5_no_bypass", 32'(st_ready), 32'h0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 32'h610 + 32'(4 * i), 32'h61 + 32'(i), Word, 1'b0, 32'h0, Word);
            chk("t5_steady", 32'(st_ready), 32'h1);
            tick();
        end
        idle(4);
        // reset discards pending stores without writing in the reset cycle
        for (int i = 0; i < 3; i++) pushHold(32'h800 + 32'(4 * i), 32'h80 + 32'(i), Word);
        drive(1'b0, 1'b0, 32'h0, 32'h0, Word, 1'b0, 32'h0, Word);
        chk("t6_rst_we", 32'(mem_WE), 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h0, Word, 1'b0, 32'h0, Word);
        chk("t6_empty", 32'(empty), 32'h1);
        chk("t6_we", 32'(mem_WE), 32'h0);
        tick();
        idle(3);
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)),
                  32'h700 + 32'($urandom_range(0, 15)), $urandom, byte_format'($urandom_range(0, 2)),
                  $urandom_range(0, 9) < 4, 32'h700 + 32'($urandom_range(0, 15)),
                  byte_format'($urandom_range(0, 2)));
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
